// File: rtl/decode_stage.sv
// Splits {opcode,src1,src2,dst} into a one-entry valid/ready register: 1-cycle latency, in_ready drops when full and
// not drained, or on a hazard. Defining DECODE_SCOREBOARD_EN adds the RAW/WAW busy scoreboard and stall counter.
module decode_stage #(
    parameter int OP_W    = 4,
    parameter int RA_W    = 4,
    parameter int NOWR_OP = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W+3*RA_W-1:0]   instruction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          opcode,
    output logic [RA_W-1:0]          srcadd_1,
    output logic [RA_W-1:0]          srcadd_2,
    output logic [RA_W-1:0]          dstadd,
    input  logic                     wb_valid,
    input  logic [RA_W-1:0]          wb_addr,
    output logic [15:0]              stall_cnt
);
    localparam int INSTR_W = OP_W + 3*RA_W;
    localparam int NREG = 2**RA_W;
    localparam logic [OP_W-1:0] NOWR = OP_W'(NOWR_OP);

    logic [OP_W-1:0] in_op;
    logic [RA_W-1:0] in_src1;
    logic [RA_W-1:0] in_src2;
    logic [RA_W-1:0] in_dst;
    logic            hazard;
    logic            accept;

    assign {in_op, in_src1, in_src2, in_dst} = instruction[INSTR_W-1:0];
    assign in_ready = !reset && !flush && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Field registers deliberately hold their value when the entry drains or is flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            srcadd_1  <= '0;
            srcadd_2  <= '0;
            dstadd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            opcode    <= in_op;
            srcadd_1  <= in_src1;
            srcadd_2  <= in_src2;
            dstadd    <= in_dst;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] eff_busy;

    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask[wb_addr] = 1'b1;
    end

    // Kept apart from wb_mask so the accept -> set path is not seen as a loop.
    always_comb begin
        set_mask = '0;
        if (accept && in_op != NOWR) set_mask[in_dst] = 1'b1;
    end

    assign eff_busy = busy & ~wb_mask;
    assign hazard   = eff_busy[in_src1] || eff_busy[in_src2] ||
                      (in_op != NOWR && eff_busy[in_dst]);

    always_ff @(posedge clk) begin
        if (reset || flush) busy <= '0;
        else                busy <= (busy & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (in_valid && !in_ready && hazard && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_addr, NREG[0]};
    assign hazard    = 1'b0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage against a field-level reference model.
module tb_decode_stage;
`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, wb_valid;
    logic [15:0] instruction, stall_cnt;
    logic [3:0]  opcode, srcadd_1, srcadd_2, dstadd, wb_addr;

    int n_tests = 0;
    int n_fail  = 0;

    bit m_valid;
    int m_op, m_s1, m_s2, m_dst, m_stall;
    bit m_busy[16];

    decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .srcadd_1(srcadd_1), .srcadd_2(srcadd_2), .dstadd(dstadd),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit eff_busy(int r);
        return m_busy[r] && !(wb_valid && int'(wb_addr) == r);
    endfunction

    function automatic bit m_hazard();
        int v = int'(instruction);
        if (!SB) return 1'b0;
        return eff_busy((v / 256) % 16) || eff_busy((v / 16) % 16) ||
               ((v / 4096) != 0 && eff_busy(v % 16));
    endfunction

    function automatic bit m_ready();
        return !reset && !flush && (!m_valid || out_ready) && !m_hazard();
    endfunction

    // Advances the model across one rising edge using the inputs currently applied.
    task automatic tick();
        bit r = reset, f = flush, wbv = wb_valid, orr = out_ready;
        int wba = int'(wb_addr);
        int v = int'(instruction);
        bit acc = in_valid && m_ready();
        bit inc = in_valid && !m_ready() && m_hazard();
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_op = 0; m_s1 = 0; m_s2 = 0; m_dst = 0; m_stall = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end else begin
            if (inc && m_stall < 65535) m_stall++;
            if (f) begin
                m_valid = 0;
                foreach (m_busy[i]) m_busy[i] = 0;
            end else begin
                if (SB && wbv) m_busy[wba] = 0;
                if (acc) begin
                    m_valid = 1;
                    m_op = v / 4096; m_s1 = (v / 256) % 16; m_s2 = (v / 16) % 16; m_dst = v % 16;
                    if (SB && m_op != 0) m_busy[m_dst] = 1;
                end else if (m_valid && orr) begin
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic idle();
        in_valid = 0; wb_valid = 0; flush = 0; reset = 0; out_ready = 1;
    endtask

    task automatic offer(input logic [15:0] ins);
        instruction = ins; in_valid = 1;
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; in_valid = 1; instruction = 16'h1234; out_ready = 1;
        wb_valid = 0; wb_addr = 0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tick(); tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== 17'h0)
            begin n_fail++; $display("FAIL reset_outputs got v=%b %h%h%h%h exp all 0", out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        n_tests++;
        if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got %h exp 0", stall_cnt); end
        idle();
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        idle(); offer(16'h1234);
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== {1'b1, 16'h1234})
            begin n_fail++; $display("FAIL stream_first got v=%b %h%h%h%h exp 1 1234", out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        offer(16'h5678); wb_valid = 1; wb_addr = 4;
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== {1'b1, 16'h5678})
            begin n_fail++; $display("FAIL stream_second got v=%b %h%h%h%h exp 1 5678", out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        in_valid = 0; wb_addr = 8;
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== {1'b0, 16'h5678})
            begin n_fail++; $display("FAIL stream_drain got v=%b %h%h%h%h exp 0 5678", out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        wb_valid = 0;
    endtask

    task automatic test_raw();
        idle(); flush = 1; tick(); flush = 0;
        offer(16'h1003); tick();
        offer(16'h2304);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (in_ready !== !SB) begin n_fail++; $display("FAIL raw_ready[%0d] got %b exp %b", i, in_ready, !SB); end
            tick();
            n_tests++;
            if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL raw_stall[%0d] got %0d exp %0d", i, stall_cnt, m_stall); end
        end
        wb_valid = 1; wb_addr = 3;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b exp 1", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1} !== {1'b1, 4'h2, 4'h3})
            begin n_fail++; $display("FAIL raw_issue got v=%b op=%h s1=%h exp 1 2 3", out_valid, opcode, srcadd_1); end
        idle();
    endtask

    task automatic test_backpressure();
        idle(); flush = 1; tick(); flush = 0;
        out_ready = 0; offer(16'h1111); tick();
        offer(16'h2222);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
            tick();
            n_tests++;
            if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== {1'b1, 16'h1111})
                begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b %h%h%h%h exp 1 1111", i, out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        end
        out_ready = 1;
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1, srcadd_2, dstadd} !== {1'b1, 16'h2222})
            begin n_fail++; $display("FAIL bp_replace got v=%b %h%h%h%h exp 1 2222", out_valid, opcode, srcadd_1, srcadd_2, dstadd); end
        idle();
    endtask

    task automatic test_collision();
        idle(); flush = 1; tick(); flush = 0;
        offer(16'h1005); tick();
        offer(16'h3125); wb_valid = 1; wb_addr = 5;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL coll_accept got %b exp 1", in_ready); end
        tick();
        wb_valid = 0; offer(16'h4500);
        #1;
        n_tests++;
        if (in_ready !== !SB) begin n_fail++; $display("FAIL coll_stall got %b exp %b", in_ready, !SB); end
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle(); flush = 1; tick(); flush = 0;
        offer(16'h1013); tick();
        offer(16'h1024); tick();
        flush = 1; offer(16'h7777);
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, opcode, dstadd} !== {1'b0, 4'h1, 4'h4})
            begin n_fail++; $display("FAIL flush_out got v=%b op=%h dst=%h exp 0 1 4", out_valid, opcode, dstadd); end
        flush = 0; offer(16'h5340);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_free got %b exp 1", in_ready); end
        tick();
        idle();
    endtask

    task automatic test_nowr();
        idle(); flush = 1; tick(); flush = 0;
        offer(16'h0099); tick(); tick();
        offer(16'h1990);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL nowr_free got %b exp 1", in_ready); end
        tick();
        n_tests++;
        if ({out_valid, opcode, srcadd_1} !== {1'b1, 4'h1, 4'h9})
            begin n_fail++; $display("FAIL nowr_issue got v=%b op=%h s1=%h exp 1 1 9", out_valid, opcode, srcadd_1); end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 19) == 0);
            in_valid = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_addr = 4'($urandom_range(0, 3));
            instruction = 16'($urandom_range(0, 3) * 4096 + $urandom_range(0, 3) * 256 +
                              $urandom_range(0, 3) * 16 + $urandom_range(0, 3));
            #1;
            n_tests++;
            if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, m_ready()); end
            tick();
            n_tests++;
            if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, m_valid); end
            n_tests++;
            if ({opcode, srcadd_1, srcadd_2, dstadd} !== {4'(m_op), 4'(m_s1), 4'(m_s2), 4'(m_dst)})
                begin n_fail++; $display("FAIL rnd_fields[%0d] got %h%h%h%h exp %h%h%h%h", i, opcode, srcadd_1, srcadd_2, dstadd, m_op, m_s1, m_s2, m_dst); end
            n_tests++;
            if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, stall_cnt, m_stall); end
        end
        idle();
    endtask

    task automatic test_saturation();
        int guard = 0;
        idle(); flush = 1; tick(); flush = 0;
        offer(16'h1003); tick();
        offer(16'h2300);
        while (m_stall < 65535 && guard < 70000) begin
            tick();
            guard++;
        end
        tick(); tick();
        n_tests++;
        if (stall_cnt !== (SB ? 16'hFFFF : 16'h0))
            begin n_fail++; $display("FAIL sat_count got %h exp %h", stall_cnt, SB ? 16'hFFFF : 16'h0); end
        idle(); wb_valid = 1; wb_addr = 3; tick(); idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_raw();
        test_backpressure();
        test_collision();
        test_flush();
        test_nowr();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction decode stage for the miniCPU FDE pipeline, placed between fetch and execute. It splits an instruction word into opcode, two source register addresses and a destination register address, with parametrised field widths. It holds the result in a one-entry pipeline register with valid/ready flow control. An optional register scoreboard stalls issue on RAW and WAW hazards until writeback.

## Interface
Parameters:
- `OP_W`, default 4: opcode field width.
- `RA_W`, default 4: register address field width.
- `NOWR_OP`, default 0: opcode value that writes no register. It neither sets nor checks busy on its destination.
- Derived localparam `INSTR_W = OP_W + 3*RA_W`, 16 at defaults. The layout is `{opcode, src1, src2, dst}`, MSB to LSB.

Ports:
- `clk`, in, 1: single clock. All state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: discards the held instruction and clears the scoreboard.
- `in_valid`, in, 1: an instruction is offered.
- `in_ready`, out, 1: the stage accepts the offered instruction this cycle.
- `instruction`, in, INSTR_W: instruction word.
- `out_valid`, out, 1: decoded fields are valid.
- `out_ready`, in, 1: execute consumes the held fields this cycle.
- `opcode`, out, OP_W: decoded opcode.
- `srcadd_1`, out, RA_W: source 1 register address.
- `srcadd_2`, out, RA_W: source 2 register address.
- `dstadd`, out, RA_W: destination register address.
- `wb_valid`, in, 1: writeback is completing this cycle.
- `wb_addr`, in, RA_W: register being written back.
- `stall_cnt`, out, 16: saturating count of hazard-stall cycles.

## Operation
- Transfer rules:
  - An input transfer happens when `in_valid && in_ready`.
  - An output transfer happens when `out_valid && out_ready`.
- `in_ready = !reset && !flush && (!out_valid || out_ready) && !hazard`.
  - `in_ready` is combinational from `instruction`, `wb_*`, `out_*` and `flush`.
  - It never depends on `in_valid`.
- Hazard logic, only when the scoreboard is compiled in:
  - `busy[r]` is an effective busy bit per register, `2**RA_W` bits in total.
  - `eff_busy[r] = busy[r] && !(wb_valid && wb_addr == r)`. Same-cycle writeback bypasses the busy bit.
  - `hazard = eff_busy[src1] || eff_busy[src2] || (opcode != NOWR_OP && eff_busy[dst])`.
- On an input transfer:
  - The fields are registered into the outputs and `out_valid` is set.
  - If `opcode != NOWR_OP`, `busy[dst]` is set.
- When there is an output transfer and no input transfer, `out_valid` clears. The field registers hold their last value.
- `wb_valid` clears `busy[wb_addr]`.
  - If a set and a clear hit the same address in one cycle, the set wins.
  - Writeback to a register that is not busy is ignored.
- `flush`:
  - Next cycle `out_valid=0` and all `busy=0`.
  - No input is accepted during the flush cycle.
  - `flush` takes priority over writeback and transfers.
- `stall_cnt` increments when `in_valid && !in_ready && hazard`. It saturates at 16'hFFFF and is cleared only by `reset`, not by `flush`.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears with `out_valid=1` after edge N.
- Throughput is 1 instruction per cycle when no hazard and `out_ready=1`.
- A hazard stall releases in the same cycle as the matching `wb_valid`, through the bypass.
- The outputs hold stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `opcode=0`, `srcadd_1=0`, `srcadd_2=0`, `dstadd=0`, `busy=0`, `stall_cnt=0`. `in_ready=0` while `reset` is high.
- Reset asserted mid-stall or with a held instruction drops everything on the next edge. No output transfer is reported for that cycle.
- `in_valid` may deassert while stalled. The stage keeps no state about an offered but unaccepted instruction.

## Configuration
- `DECODE_SCOREBOARD_EN` defined: the scoreboard, hazard logic and `stall_cnt` are as described above.
- `DECODE_SCOREBOARD_EN` not defined:
  - `hazard` is tied to 0, no `busy` register is built, and `stall_cnt` is tied to 0.
  - `wb_valid` and `wb_addr` are ignored.
  - The block is a pure registered decode with handshake.

## Test plan
- Reset then stream: defaults, `out_ready=1`, instruction 16'h1234 then 16'h5678, each only after the previous one's `wb_addr` writeback. Expected: outputs `opcode=1`, `src1=2`, `src2=3`, `dst=4` one cycle after acceptance, then 5/6/7/8 the following cycle.
- RAW stall:
  - Accept 16'h1003, which sets `busy[3]`.
  - Offer 16'h2304. Expected: `in_ready=0` and `stall_cnt` increments each cycle.
  - Pulse `wb_valid`, `wb_addr=3`. Expected: accepted that same cycle.
- Backpressure: hold `out_ready=0` with the stage full. Expected: `in_ready=0`, fields stable, and with `out_ready=1` and a new instruction presented, it replaces the held one at the next edge.
- Set/clear collision:
  - `busy[5]` is set.
  - Accept 16'h3125 while `wb_valid`, `wb_addr=5`. Expected: `busy[5]` remains 1.
  - Then offer 16'h4500. Expected: stalls.
- Flush:
  - Set several busy bits with `out_valid=1`, then assert `flush` with `in_valid=1`. Expected: next cycle `out_valid=0`, all sources are free, and the instruction offered during the flush cycle was not accepted.
- `NOWR_OP` and saturation:
  - 16'h0099 accepted twice back to back. Expected: no busy bit set.
  - Force a long stall. Expected: `stall_cnt` saturates at 16'hFFFF.
  - Build without `DECODE_SCOREBOARD_EN`. Expected: the RAW stall stimulus is accepted without stall.
